dp_regbank: RTL and testbench
=============================

Name: dp_regbank

Overview:
- Parametrised successor to the fixed 8x16 CPU register array: general register file with configurable width, register count and number of banked stack pointers.
- Two read ports and two prioritised write ports.
- Built-in context sequencer that streams all registers out to memory (SAVE) or back in (LOAD) over a req/ack handshake, for trap/interrupt context switching.
- Sits between the microcode control vector and the ALU/bus muxes of the CPU datapath.

Parameters:
- DW, 16: register data width.
- NREG, 8: number of architectural registers; power of two, minimum 4.
- NBANK, 2: number of stack-pointer banks; only register SPIDX is banked.
- SPIDX, 6: index of the banked stack pointer.
- PCIDX, 7: index of the program counter.
- RESET_PC, 16'o100000: PC value after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; all state changes are qualified by ce.
- bank_i  in  $clog2(NBANK)  current SP bank (0 = kernel).
- ra_addr  in  $clog2(NREG)  read port A address.
- ra_data  out  DW  read port A data.
- rb_addr  in  $clog2(NREG)  read port B address.
- rb_data  out  DW  read port B data.
- wa_en  in  1  write port A enable.
- wa_addr  in  $clog2(NREG)  write port A address.
- wa_data  in  DW  write port A data.
- wb_en  in  1  write port B enable.
- wb_addr  in  $clog2(NREG)  write port B address.
- wb_data  in  DW  write port B data.
- pc_out  out  DW  PC, always visible.
- sp_out  out  DW  SP of the current bank_i.
- ctx_start  in  1  start-sequence pulse.
- ctx_load  in  1  sampled with ctx_start; 0 = SAVE, 1 = LOAD.
- ctx_busy  out  1  sequencer active.
- ctx_req  out  1  transfer request.
- ctx_idx  out  $clog2(NREG)  register index of the current transfer.
- ctx_wdata  out  DW  register value (SAVE).
- ctx_rdata  in  DW  value to restore (LOAD).
- ctx_ack  in  1  transfer accepted.
- ctx_done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (asynchronous):
  - All registers and all SP banks are 0, except PC = RESET_PC.
  - Sequencer is in IDLE.
  - ctx_busy, ctx_req, ctx_done are 0; ctx_idx is 0; ctx_wdata is 0.
- Reads:
  - Combinational, zero latency.
  - An address equal to SPIDX selects the SP of bank_i. With ctx_busy high it selects the latched bank instead.
  - pc_out and sp_out follow the same rule.
- Writes:
  - Take effect at the ce-qualified rising edge.
  - Writes to SPIDX go to the bank of bank_i.
  - If wa and wb target the same register in the same cycle, port A wins.
  - Port writes are ignored while ctx_busy is 1.
- Sequencer states:
  - IDLE: ctx_start with ce latches ctx_load and bank_i. Sets ctx_idx=0, ctx_busy=1 and goes to XFER.
  - XFER: ctx_req=1. ctx_idx and ctx_wdata (the register at ctx_idx) are held stable until ctx_ack with ce.
  - On ack in LOAD mode, register[ctx_idx] is written with ctx_rdata.
  - On ack, if ctx_idx==NREG-1 go to DONE; otherwise increment ctx_idx and stay in XFER. The next req is presented in the following cycle with no gap cycle.
  - DONE: ctx_done=1 for one cycle, ctx_busy=0, ctx_req=0, then IDLE. ctx_busy falls in the same cycle ctx_done rises.
- Boundary conditions:
  - ctx_start while busy: ignored.
  - ctx_ack outside XFER: ignored.
  - ack held high continuously: one register is transferred per ce cycle.
  - ce low: everything freezes, including the sequencer.
  - reset mid-sequence: returns to IDLE immediately. Registers already loaded keep their reset values (reset overrides).
- Transfer order and latency:
  - Order is ascending index 0..NREG-1.
  - Minimum sequence latency is NREG+1 ce cycles from start to done, with ack tied high.

Optional Feature:
- Macro: DP_REGBANK_BYPASS_EN.
- Defined: a read port addressing the register being written this cycle returns the incoming write data combinationally.
  - Port A data wins on collision.
  - Applies to ra_data, rb_data, pc_out and sp_out.
  - Not applied while busy.
- Undefined: reads return the stored value; new data is visible the cycle after the write.

Test Plan:
- Reset, then read all registers: PC=0o100000, all others 0. Deassert reset, write wa R3=0o123456, then read ra R3: 0o123456 on the next cycle.
- Banked SP: with bank_i=0 write R6=0o1000; with bank_i=1 write R6=0o2000. sp_out reads 0o1000 with bank_i=0 and 0o2000 with bank_i=1.
- Collision: wa and wb both write R2, A=0o111 and B=0o222, then R2 reads 0o111. wb alone to R4=0o333 in the same cycle also lands.
- SAVE with ack delayed 2 cycles per transfer: ctx_idx steps 0..7 with ctx_wdata equal to each register. ctx_done pulses once after idx 7. Port writes issued during the sequence leave all registers unchanged.
- LOAD with ack tied high and ctx_rdata=0o100+idx: done at cycle 9 after start; Rn then reads 0o100+n.
- Reset asserted at idx 3 of a LOAD: busy/req drop asynchronously, PC=0o100000 and R0..R2=0. With BYPASS_EN defined, writing R1=0o7 shows ra(R1)=0o7 in the same cycle.

Source files
------------

// File: rtl/dp_regbank_if.sv
// Register-bank bus: read/write ports plus the context-sequencer handshake (ctx_req/ctx_ack).
// The master drives the ports; the slave is the register bank.
interface dp_regbank_if #(
  parameter int DW    = 16,
  parameter int NREG  = 8,
  parameter int NBANK = 2
);
  localparam int AW = $clog2(NREG);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic          ce;
  logic [BW-1:0] bank_i;
  logic [AW-1:0] ra_addr;
  logic [DW-1:0] ra_data;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] rb_data;
  logic          wa_en;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] sp_out;
  logic          ctx_start;
  logic          ctx_load;
  logic          ctx_busy;
  logic          ctx_req;
  logic [AW-1:0] ctx_idx;
  logic [DW-1:0] ctx_wdata;
  logic [DW-1:0] ctx_rdata;
  logic          ctx_ack;
  logic          ctx_done;

  modport master (
    output ce, bank_i, ra_addr, rb_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, ctx_start, ctx_load, ctx_rdata, ctx_ack,
    input  ra_data, rb_data, pc_out, sp_out, ctx_busy, ctx_req, ctx_idx,
           ctx_wdata, ctx_done
  );

  modport slave (
    input  ce, bank_i, ra_addr, rb_addr, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, ctx_start, ctx_load, ctx_rdata, ctx_ack,
    output ra_data, rb_data, pc_out, sp_out, ctx_busy, ctx_req, ctx_idx,
           ctx_wdata, ctx_done
  );
endinterface

// File: rtl/dp_regbank.sv
// Banked-SP register file with a SAVE/LOAD context sequencer; reads are zero latency, writes land on the ce edge.
// The sequencer holds each transfer until ctx_ack; DP_REGBANK_BYPASS_EN forwards same-cycle write data to reads.
module dp_regbank #(
  parameter int            DW       = 16,
  parameter int            NREG     = 8,
  parameter int            NBANK    = 2,
  parameter int            SPIDX    = 6,
  parameter int            PCIDX    = 7,
  parameter logic [DW-1:0] RESET_PC = DW'(16'o100000)
) (
  input logic         clk,
  input logic         reset,
  dp_regbank_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [AW-1:0] SP_A   = AW'(SPIDX);
  localparam logic [AW-1:0] PC_A   = AW'(PCIDX);
  localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);
  localparam int NRD = 5;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx_q, idx_nxt;
  logic [BW-1:0] bank_q, bank_nxt;
  logic          load_q, load_nxt;

  logic [DW-1:0] regs    [NREG];
  logic [DW-1:0] sp_bank [NBANK];

  logic          busy;
  logic          port_wr;
  logic [BW-1:0] eff_bank;
  logic [AW-1:0] rd_addr [NRD];
  logic [DW-1:0] rd_val  [NRD];

  assign busy     = (state == S_XFER);
  assign port_wr  = bus.ce && !busy;
  assign eff_bank = busy ? bank_q : bus.bank_i;

  // Read taps: A, B, PC, SP, and the sequencer's own transfer slot.
  assign rd_addr[0] = bus.ra_addr;
  assign rd_addr[1] = bus.rb_addr;
  assign rd_addr[2] = PC_A;
  assign rd_addr[3] = SP_A;
  assign rd_addr[4] = idx_q;

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_val[p] = (rd_addr[p] == SP_A) ? sp_bank[eff_bank] : regs[rd_addr[p]];
`ifdef DP_REGBANK_BYPASS_EN
      if (port_wr) begin
        if (bus.wb_en && (bus.wb_addr == rd_addr[p])) rd_val[p] = bus.wb_data;
        if (bus.wa_en && (bus.wa_addr == rd_addr[p])) rd_val[p] = bus.wa_data;
      end
`endif
    end
  end

  assign bus.ra_data   = rd_val[0];
  assign bus.rb_data   = rd_val[1];
  assign bus.pc_out    = rd_val[2];
  assign bus.sp_out    = rd_val[3];
  assign bus.ctx_wdata = busy ? rd_val[4] : '0;
  assign bus.ctx_busy  = busy;
  assign bus.ctx_req   = busy;
  assign bus.ctx_done  = (state == S_DONE);
  assign bus.ctx_idx   = idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      bank_q <= '0;
      load_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      bank_q <= bank_nxt;
      load_q <= load_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    bank_nxt  = bank_q;
    load_nxt  = load_q;
    if (bus.ce) begin
      case (state)
        S_IDLE: if (bus.ctx_start) begin
          state_nxt = S_XFER;
          idx_nxt   = '0;
          bank_nxt  = bus.bank_i;
          load_nxt  = bus.ctx_load;
        end
        S_XFER: if (bus.ctx_ack) begin
          if (idx_q == LAST_A) state_nxt = S_DONE;
          else                 idx_nxt   = idx_q + AW'(1);
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Port B is applied first so port A overrides it on a same-register collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= (i == PCIDX) ? RESET_PC : '0;
      for (int b = 0; b < NBANK; b++) sp_bank[b] <= '0;
    end else if (bus.ce) begin
      if (busy) begin
        if (load_q && bus.ctx_ack) begin
          if (idx_q == SP_A) sp_bank[bank_q] <= bus.ctx_rdata;
          else               regs[idx_q]     <= bus.ctx_rdata;
        end
      end else begin
        if (bus.wb_en) begin
          if (bus.wb_addr == SP_A) sp_bank[bus.bank_i] <= bus.wb_data;
          else                     regs[bus.wb_addr]   <= bus.wb_data;
        end
        if (bus.wa_en) begin
          if (bus.wa_addr == SP_A) sp_bank[bus.bank_i] <= bus.wa_data;
          else                     regs[bus.wa_addr]   <= bus.wa_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_dp_regbank.sv
// Directed bench for dp_regbank: the driver queues expected values, a negedge monitor pops and compares them.
module tb_dp_regbank;
  logic clk;
  logic reset;

  dp_regbank_if #(.DW(16), .NREG(8), .NBANK(2)) bus ();

  dp_regbank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Restore data is a function of the index being transferred.
  assign bus.ctx_rdata = 16'o100 + 16'(bus.ctx_idx);

  typedef struct {
    int          tag;
    int          sel;
    logic [15:0] val;
  } chk_t;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] wd;
    logic        chk_w;
  } xfer_t;

  chk_t  chk_q  [$];
  xfer_t xfer_q [$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  int    tag_cnt  = 0;

  logic [15:0] exp_r  [8];
  logic [15:0] exp_sp [2];

  function automatic string sig_name(input int sel);
    case (sel)
      0: return "ra_data";
      1: return "rb_data";
      2: return "pc_out";
      3: return "sp_out";
      4: return "ctx_busy";
      5: return "ctx_req";
      6: return "ctx_done";
      7: return "ctx_idx";
      default: return "ctx_wdata";
    endcase
  endfunction

  function automatic logic [15:0] get_sig(input int sel);
    case (sel)
      0: return bus.ra_data;
      1: return bus.rb_data;
      2: return bus.pc_out;
      3: return bus.sp_out;
      4: return {15'd0, bus.ctx_busy};
      5: return {15'd0, bus.ctx_req};
      6: return {15'd0, bus.ctx_done};
      7: return 16'(bus.ctx_idx);
      default: return bus.ctx_wdata;
    endcase
  endfunction

  // Monitor: signal checks queued for this cycle, plus one transfer per req/ack handshake.
  always @(negedge clk) begin
    chk_t        c;
    xfer_t       x;
    logic [15:0] a;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      a = get_sig(c.sel);
      n_tests++;
      if (a !== c.val) begin
        n_fail++;
        $display("FAIL chk%0d %s: got %o, expected %o", c.tag, sig_name(c.sel), a, c.val);
      end
    end
    if (bus.ctx_req === 1'b1 && bus.ctx_ack === 1'b1) begin
      n_tests++;
      if (xfer_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got idx %0d, expected no transfer", bus.ctx_idx);
      end else begin
        x = xfer_q.pop_front();
        if (bus.ctx_idx !== x.idx || (x.chk_w && bus.ctx_wdata !== x.wd)) begin
          n_fail++;
          $display("FAIL xfer: got idx %0d wdata %o, expected idx %0d wdata %o",
                   bus.ctx_idx, bus.ctx_wdata, x.idx, x.wd);
        end
      end
    end
    if (bus.ctx_done === 1'b1) done_cnt++;
  end

  task automatic expect_sig(input int sel, input logic [15:0] val);
    chk_t c;
    tag_cnt++;
    c.tag = tag_cnt;
    c.sel = sel;
    c.val = val;
    chk_q.push_back(c);
  endtask

  task automatic expect_xfer(input int idx, input logic [15:0] wd, input logic chk_w);
    xfer_t x;
    x.idx   = 3'(idx);
    x.wd    = wd;
    x.chk_w = chk_w;
    xfer_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reads every register via both ports against the bench model for the current bank_i.
  task automatic check_all(input int bank);
    for (int i = 0; i < 8; i++) begin
      bus.ra_addr = 3'(i);
      bus.rb_addr = 3'(7 - i);
      expect_sig(0, (i == 6) ? exp_sp[bank] : exp_r[i]);
      expect_sig(1, (7 - i == 6) ? exp_sp[bank] : exp_r[7 - i]);
      settle();
      tick();
    end
  endtask

  task automatic wr_a(input int addr, input logic [15:0] d);
    bus.wa_en   = 1'b1;
    bus.wa_addr = 3'(addr);
    bus.wa_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce = 1'b1; bus.bank_i = '0; bus.ra_addr = '0; bus.rb_addr = '0;
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ctx_start = 1'b0; bus.ctx_load = 1'b0; bus.ctx_ack = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) exp_r[i] = (i == 7) ? 16'o100000 : 16'o0;
    exp_sp[0] = 16'o0; exp_sp[1] = 16'o0;

    // Reset state
    expect_sig(4, 0); expect_sig(5, 0); expect_sig(6, 0); expect_sig(7, 0); expect_sig(8, 0);
    expect_sig(2, 16'o100000);
    settle();
    check_all(0);
    reset = 1'b0;

    // Write then read next cycle
    wr_a(3, 16'o123456);
    tick();
    bus.wa_en = 1'b0; bus.ra_addr = 3'd3; exp_r[3] = 16'o123456;
    expect_sig(0, 16'o123456);
    settle(); tick();

    // Banked stack pointer
    bus.bank_i = 1'b0; wr_a(6, 16'o1000); tick();
    bus.bank_i = 1'b1; wr_a(6, 16'o2000); tick();
    bus.wa_en = 1'b0; exp_sp[0] = 16'o1000; exp_sp[1] = 16'o2000;
    bus.ra_addr = 3'd6;
    expect_sig(3, 16'o2000); expect_sig(0, 16'o2000);
    settle(); tick();
    bus.bank_i = 1'b0;
    expect_sig(3, 16'o1000); expect_sig(0, 16'o1000);
    settle(); tick();

    // Port collision, then independent dual write
    wr_a(2, 16'o111);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'o222;
    tick();
    wr_a(5, 16'o555);
    bus.wb_addr = 3'd4; bus.wb_data = 16'o333;
    tick();
    bus.wa_en = 1'b0; bus.wb_en = 1'b0;
    exp_r[2] = 16'o111; exp_r[4] = 16'o333; exp_r[5] = 16'o555;
    check_all(0);

    // SAVE from bank 1 with ack delayed two cycles; port writes must be ignored
    bus.bank_i = 1'b1; bus.ctx_load = 1'b0; bus.ctx_start = 1'b1;
    for (int k = 0; k < 8; k++) expect_xfer(k, (k == 6) ? exp_sp[1] : exp_r[k], 1'b1);
    tick();
    bus.ctx_start = 1'b0; bus.bank_i = 1'b0;
    wr_a(0, 16'o777);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'o666;
    expect_sig(4, 1); expect_sig(5, 1); expect_sig(7, 0); expect_sig(3, 16'o2000);
    for (int k = 0; k < 8; k++) begin
      bus.ctx_ack = 1'b0;
      if (k == 3) bus.ctx_start = 1'b1;
      tick();
      bus.ctx_start = 1'b0;
      tick();
      bus.ctx_ack = 1'b1;
      if (k == 7) begin bus.wa_en = 1'b0; bus.wb_en = 1'b0; end
      tick();
    end
    bus.ctx_ack = 1'b0;
    expect_sig(6, 1); expect_sig(4, 0); expect_sig(5, 0);
    settle(); tick();
    expect_sig(6, 0); expect_sig(4, 0);
    settle(); tick();
    check_all(0);

    // LOAD into bank 0 with ack tied high: done in cycle 9
    bus.ctx_load = 1'b1; bus.ctx_start = 1'b1; bus.ctx_ack = 1'b1;
    for (int k = 0; k < 8; k++) expect_xfer(k, 16'o0, 1'b0);
    tick();
    bus.ctx_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      expect_sig(6, (c == 9) ? 16'd1 : 16'd0);
      expect_sig(4, (c < 9) ? 16'd1 : 16'd0);
      settle();
      if (c < 9) tick();
    end
    tick();
    bus.ctx_ack = 1'b0;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'o100 + 16'(i);
    exp_sp[0] = 16'o106;
    check_all(0);
    bus.bank_i = 1'b1;
    expect_sig(3, 16'o2000);
    settle(); tick();
    bus.bank_i = 1'b0;

    // Reset during LOAD at idx 3
    bus.ctx_start = 1'b1; bus.ctx_ack = 1'b1;
    for (int k = 0; k < 3; k++) expect_xfer(k, 16'o0, 1'b0);
    tick();
    bus.ctx_start = 1'b0;
    tick(); tick(); tick();
    bus.ctx_ack = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) exp_r[i] = (i == 7) ? 16'o100000 : 16'o0;
    exp_sp[0] = 16'o0; exp_sp[1] = 16'o0;
    bus.ra_addr = 3'd0; bus.rb_addr = 3'd1;
    expect_sig(4, 0); expect_sig(5, 0); expect_sig(7, 0);
    expect_sig(2, 16'o100000); expect_sig(0, 0); expect_sig(1, 0);
    settle(); tick();
    bus.ra_addr = 3'd2;
    expect_sig(0, 0);
    settle(); tick();
    reset = 1'b0;

    // Clock enable low freezes writes and the sequencer
    bus.ce = 1'b0; wr_a(3, 16'o55); bus.ctx_start = 1'b1;
    tick();
    bus.wa_en = 1'b0; bus.ctx_start = 1'b0; bus.ra_addr = 3'd3;
    expect_sig(4, 0); expect_sig(0, 0);
    settle(); tick();
    bus.ce = 1'b1;

    // Same-cycle read of a register being written
    wr_a(1, 16'o7); bus.ra_addr = 3'd1;
`ifdef DP_REGBANK_BYPASS_EN
    expect_sig(0, 16'o7);
`else
    expect_sig(0, 16'o0);
`endif
    settle(); tick();
    bus.wa_en = 1'b0;
    expect_sig(0, 16'o7);
    settle(); tick();

    // End-of-run bookkeeping
    n_tests++;
    if (done_cnt != 2) begin
      n_fail++;
      $display("FAIL done_count: got %0d, expected 2", done_cnt);
    end
    n_tests++;
    if (xfer_q.size() != 0) begin
      n_fail++;
      $display("FAIL xfer_pending: got %0d, expected 0", xfer_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
